store_buffer: RTL and testbench

Posted-write buffer placed directly upstream of the data memory, between the MEM stage and the memory port. Stores are queued in a small FIFO and drained into memory one per cycle whenever the port is not needed by a load. Loads have priority on the port. Loads whose address matches a pending store are forwarded from the buffer, youngest entry first, so the pipeline sees program-order data.

---
 rtl/store_buffer_pkg.sv | 37 +++
 rtl/store_buffer_fifo.sv | 80 ++++++++
 rtl/store_buffer.sv | 101 ++++++++++
 tb/tb_store_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and the youngest-match search for the store buffer.
// Latency: pure combinational helpers. Backpressure: none.
// STORE_BUF_FWD_EN selects whether the search result feeds load forwarding.
package store_buffer_pkg;

   localparam int SB_DEPTH  = 4;
   localparam int SB_ADDR_W = 32;
   localparam int SB_DATA_W = 32;
   localparam int SB_PTR_W  = $clog2(SB_DEPTH);

   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] data;
   } entry_t;

   typedef struct packed {
      logic                hit;
      logic [SB_PTR_W-1:0] idx;
   } hit_t;

   // Walks from oldest to youngest so the entry nearest tail wins.
   function automatic hit_t youngest_hit(input logic [SB_DEPTH-1:0] match,
                                         input logic [SB_PTR_W-1:0] tail);
      hit_t                r;
      logic [SB_PTR_W-1:0] idx;
      r = '0;
      for (int k = SB_DEPTH; k >= 1; k--) begin
         idx = tail - SB_PTR_W'(k);
         if (match[idx]) begin
            r.hit = 1'b1;
            r.idx = idx;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store queue with per-slot valid bits and a flat view of all slots.
// Latency: push/pop take effect at posedge; head is visible combinationally.
// Backpressure: push ignored when full, pop ignored when empty.
module store_buffer_fifo
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic                    push,
   input  logic [ADDR_W-1:0]       push_addr,
   input  logic [DATA_W-1:0]       push_data,
   input  logic                    pop,
   output logic                    full,
   output logic                    empty,
   output logic [CNT_W-1:0]        count,
   output logic [PTR_W-1:0]        tail_ptr,
   output logic [ADDR_W-1:0]       head_addr,
   output logic [DATA_W-1:0]       head_data,
   output logic [DEPTH-1:0]        ent_vld,
   output logic [DEPTH*ADDR_W-1:0] ent_addr,
   output logic [DEPTH*DATA_W-1:0] ent_data
);

   entry_t           mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Push and pop never share a slot: a legal push means the queue is not full.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
         vld     <= '0;
      end else begin
         if (do_push) begin
            vld[tail] <= 1'b1;
            tail      <= tail + 1'b1;
         end
         if (do_pop) begin
            vld[head] <= 1'b0;
            head      <= head + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (do_push) mem[tail] <= '{addr: push_addr, data: push_data};
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_view
      assign ent_addr[i*ADDR_W +: ADDR_W] = mem[i].addr;
      assign ent_data[i*DATA_W +: DATA_W] = mem[i].data;
   end

   assign ent_vld   = vld;
   assign count     = count_q;
   assign tail_ptr  = tail;
   assign head_addr = mem[head].addr;
   assign head_data = mem[head].data;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of data memory; loads own the port, stores drain when idle.
// Latency: loads 0 cycles (forwarded or memory), stores drain one per free cycle.
// Backpressure: Stall on store-when-full; without STORE_BUF_FWD_EN also on load hitting a pending store.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              MemRead,
   input  logic              MemWrite,
   output logic [DATA_W-1:0] ReadData,
   output logic              Stall,
   output logic              Empty,
   output logic [CNT_W-1:0]  Count,
   output logic [ADDR_W-1:0] DmAddress,
   output logic [DATA_W-1:0] DmWriteData,
   output logic              DmMemRead,
   output logic              DmMemWrite,
   input  logic [DATA_W-1:0] DmReadData
);

   logic                    push, pop, full, empty;
   logic [PTR_W-1:0]        tail_ptr;
   logic [ADDR_W-1:0]       head_addr;
   logic [DATA_W-1:0]       head_data;
   logic [DEPTH-1:0]        ent_vld, match;
   logic [DEPTH*ADDR_W-1:0] ent_addr;
   logic [DEPTH*DATA_W-1:0] ent_data;
   logic                    load_blk, load_go, drain;

   store_buffer_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .push      (push),
      .push_addr (Address),
      .push_data (WriteData),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .count     (Count),
      .tail_ptr  (tail_ptr),
      .head_addr (head_addr),
      .head_data (head_data),
      .ent_vld   (ent_vld),
      .ent_addr  (ent_addr),
      .ent_data  (ent_data)
   );

   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++)
         match[i] = ent_vld[i] & (ent_addr[i*ADDR_W +: ADDR_W] == Address);
   end

`ifdef STORE_BUF_FWD_EN
   hit_t hit;
   assign hit      = youngest_hit(match, tail_ptr);
   assign load_blk = 1'b0;
`else
   // A load hitting a pending store waits; the drain is what clears the hit.
   logic unused_tail;
   assign unused_tail = ^tail_ptr;
   assign load_blk    = MemRead & (|match);
`endif

   assign load_go = MemRead & ~load_blk;
   assign drain   = ~load_go & ~empty;
   assign Stall   = (MemWrite & full) | load_blk;
   assign push    = MemWrite & ~Stall;
   assign pop     = drain;
   assign Empty   = empty;

   always_comb begin
      DmAddress   = '0;
      DmWriteData = '0;
      DmMemRead   = 1'b0;
      DmMemWrite  = 1'b0;
      ReadData    = '0;
      if (load_go) begin
         DmAddress = Address;
         DmMemRead = 1'b1;
         ReadData  = DmReadData;
`ifdef STORE_BUF_FWD_EN
         if (hit.hit) ReadData = ent_data[hit.idx*DATA_W +: DATA_W];
`endif
      end else if (drain) begin
         DmAddress   = head_addr;
         DmWriteData = head_data;
         DmMemWrite  = 1'b1;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small behavioural data memory.
// Expectations follow STORE_BUF_FWD_EN as compiled.
module tb_store_buffer;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [31:0] Address, WriteData;
   logic        MemRead, MemWrite;
   logic [31:0] ReadData;
   logic        Stall, Empty;
   logic [2:0]  Count;
   logic [31:0] DmAddress, DmWriteData, DmReadData;
   logic        DmMemRead, DmMemWrite;

   logic [31:0] mem [256];
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 Clk = ~Clk;

   store_buffer dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .Address     (Address),
      .WriteData   (WriteData),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .ReadData    (ReadData),
      .Stall       (Stall),
      .Empty       (Empty),
      .Count       (Count),
      .DmAddress   (DmAddress),
      .DmWriteData (DmWriteData),
      .DmMemRead   (DmMemRead),
      .DmMemWrite  (DmMemWrite),
      .DmReadData  (DmReadData)
   );

   assign DmReadData = mem[DmAddress[7:0]];
   always @(posedge Clk) if (DmMemWrite === 1'b1) mem[DmAddress[7:0]] <= DmWriteData;

   task automatic cyc;
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      MemRead = rd; MemWrite = wr; Address = a; WriteData = d;
      #1;
   endtask

   task automatic test_reset;
      Reset_n = 1'b0;
      drive(0, 0, 0, 0);
      n_cmp++; if (Empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", Empty); end
      n_cmp++; if (Count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", Count); end
      n_cmp++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", Stall); end
      n_cmp++; if (DmMemWrite !== 1'b0) begin n_fail++; $display("FAIL rst_dmwr got %b want 0", DmMemWrite); end
      drive(1, 0, 7, 0);
      n_cmp++; if (ReadData !== 32'h55) begin n_fail++; $display("FAIL rst_load got %h want 55", ReadData); end
      drive(0, 0, 0, 0);
      cyc; cyc;
      Reset_n = 1'b1;
   endtask

   task automatic test_basic_store;
      cyc; drive(0, 1, 5, 32'hDEADBEEF);
      n_cmp++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL basic_stall got %b want 0", Stall); end
      n_cmp++; if (DmMemWrite !== 1'b0) begin n_fail++; $display("FAIL basic_nodrain got %b want 0", DmMemWrite); end
      cyc; drive(0, 0, 0, 0);
      n_cmp++; if (Count !== 3'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", Count); end
      n_cmp++; if (DmMemWrite !== 1'b1 || DmAddress !== 32'd5 || DmWriteData !== 32'hDEADBEEF)
         begin n_fail++; $display("FAIL basic_drain got wr=%b a=%0d d=%h want 1/5/deadbeef", DmMemWrite, DmAddress, DmWriteData); end
      cyc;
      n_cmp++; if (Empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b want 1", Empty); end
      n_cmp++; if (mem[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_mem got %h want deadbeef", mem[5]); end
   endtask

   task automatic test_same_addr;
      cyc; drive(1, 1, 10, 1);
      n_cmp++; if (ReadData !== 32'hAA) begin n_fail++; $display("FAIL dup_first_load got %h want aa", ReadData); end
`ifdef STORE_BUF_FWD_EN
      cyc; drive(1, 1, 10, 2);
      n_cmp++; if (ReadData !== 32'h1) begin n_fail++; $display("FAIL dup_fwd1 got %h want 1", ReadData); end
      cyc; drive(1, 0, 10, 0);
      n_cmp++; if (ReadData !== 32'h2 || DmMemWrite !== 1'b0) begin n_fail++; $display("FAIL dup_fwd2 got %h wr=%b want 2/0", ReadData, DmMemWrite); end
      cyc;
      n_cmp++; if (Count !== 3'd2 || ReadData !== 32'h2) begin n_fail++; $display("FAIL dup_hold got cnt=%0d rd=%h want 2/2", Count, ReadData); end
      drive(0, 0, 0, 0);
      n_cmp++; if (DmWriteData !== 32'h1) begin n_fail++; $display("FAIL dup_order1 got %h want 1", DmWriteData); end
      cyc;
      n_cmp++; if (DmWriteData !== 32'h2) begin n_fail++; $display("FAIL dup_order2 got %h want 2", DmWriteData); end
      cyc;
`else
      cyc; drive(1, 1, 10, 2);
      n_cmp++; if (Stall !== 1'b1 || ReadData !== 32'h0 || DmMemRead !== 1'b0)
         begin n_fail++; $display("FAIL dup_blk got st=%b rd=%h dmrd=%b want 1/0/0", Stall, ReadData, DmMemRead); end
      n_cmp++; if (DmMemWrite !== 1'b1 || DmWriteData !== 32'h1) begin n_fail++; $display("FAIL dup_drain1 got %b/%h want 1/1", DmMemWrite, DmWriteData); end
      cyc; #1;
      n_cmp++; if (Stall !== 1'b0 || ReadData !== 32'h1) begin n_fail++; $display("FAIL dup_rel got st=%b rd=%h want 0/1", Stall, ReadData); end
      cyc; drive(1, 0, 10, 0);
      n_cmp++; if (Stall !== 1'b1 || DmWriteData !== 32'h2) begin n_fail++; $display("FAIL dup_blk2 got st=%b d=%h want 1/2", Stall, DmWriteData); end
      cyc;
      n_cmp++; if (Stall !== 1'b0 || ReadData !== 32'h2) begin n_fail++; $display("FAIL dup_rel2 got st=%b rd=%h want 0/2", Stall, ReadData); end
      drive(0, 0, 0, 0);
`endif
      n_cmp++; if (mem[10] !== 32'h2 || Empty !== 1'b1) begin n_fail++; $display("FAIL dup_mem got %h empty=%b want 2/1", mem[10], Empty); end
   endtask

   task automatic test_load_miss;
      cyc; drive(1, 0, 7, 0);
      n_cmp++; if (DmMemRead !== 1'b1 || DmAddress !== 32'd7 || DmMemWrite !== 1'b0)
         begin n_fail++; $display("FAIL miss_port got rd=%b a=%0d wr=%b want 1/7/0", DmMemRead, DmAddress, DmMemWrite); end
      n_cmp++; if (ReadData !== 32'h55) begin n_fail++; $display("FAIL miss_data got %h want 55", ReadData); end
   endtask

   task automatic test_full_stall;
      for (int i = 0; i < 4; i++) begin
         cyc; drive(1, 1, 20 + i, 32'h100 + i);
      end
      cyc; drive(1, 1, 24, 32'h124);
      n_cmp++; if (Count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", Count); end
      n_cmp++; if (Stall !== 1'b1 || DmMemWrite !== 1'b0) begin n_fail++; $display("FAIL full_stall got %b/%b want 1/0", Stall, DmMemWrite); end
      cyc;
      n_cmp++; if (Count !== 3'd4) begin n_fail++; $display("FAIL full_noenq got %0d want 4", Count); end
      drive(0, 1, 24, 32'h124);
      n_cmp++; if (Stall !== 1'b1 || DmAddress !== 32'd20) begin n_fail++; $display("FAIL full_cons got st=%b a=%0d want 1/20", Stall, DmAddress); end
      cyc;
      n_cmp++; if (Count !== 3'd3 || Stall !== 1'b0) begin n_fail++; $display("FAIL full_free got cnt=%0d st=%b want 3/0", Count, Stall); end
      cyc; drive(0, 0, 0, 0);
      n_cmp++; if (Count !== 3'd3 || DmAddress !== 32'd22) begin n_fail++; $display("FAIL full_acc got cnt=%0d a=%0d want 3/22", Count, DmAddress); end
      cyc; cyc; cyc;
      n_cmp++; if (Empty !== 1'b1 || mem[24] !== 32'h124 || mem[20] !== 32'h100)
         begin n_fail++; $display("FAIL full_mem got e=%b m24=%h m20=%h want 1/124/100", Empty, mem[24], mem[20]); end
   endtask

   task automatic test_simul;
      cyc; drive(1, 1, 30, 32'h30);
      cyc; drive(1, 1, 31, 32'h31);
      cyc; drive(0, 1, 32, 32'h32);
      n_cmp++; if (Count !== 3'd2 || DmAddress !== 32'd30) begin n_fail++; $display("FAIL sim_start got cnt=%0d a=%0d want 2/30", Count, DmAddress); end
      cyc; drive(0, 1, 33, 32'h33);
      n_cmp++; if (Count !== 3'd2 || DmAddress !== 32'd31) begin n_fail++; $display("FAIL sim_step1 got cnt=%0d a=%0d want 2/31", Count, DmAddress); end
      cyc; drive(0, 0, 0, 0);
      n_cmp++; if (Count !== 3'd2 || DmAddress !== 32'd32) begin n_fail++; $display("FAIL sim_step2 got cnt=%0d a=%0d want 2/32", Count, DmAddress); end
      cyc;
      n_cmp++; if (DmAddress !== 32'd33 || DmWriteData !== 32'h33) begin n_fail++; $display("FAIL sim_last got a=%0d d=%h want 33/33", DmAddress, DmWriteData); end
      cyc;
      n_cmp++; if (Empty !== 1'b1 || mem[31] !== 32'h31) begin n_fail++; $display("FAIL sim_mem got e=%b m31=%h want 1/31", Empty, mem[31]); end
   endtask

   task automatic test_reset_mid;
      cyc; drive(1, 1, 40, 32'h40);
      cyc; drive(1, 1, 41, 32'h41);
      cyc; drive(1, 1, 42, 32'h42);
      cyc; drive(1, 0, 42, 0);
      n_cmp++; if (Count !== 3'd3) begin n_fail++; $display("FAIL mid_count got %0d want 3", Count); end
      Reset_n = 1'b0;
      drive(0, 0, 0, 0);
      n_cmp++; if (Count !== 3'd0 || Empty !== 1'b1 || DmMemWrite !== 1'b0)
         begin n_fail++; $display("FAIL mid_rst got cnt=%0d e=%b wr=%b want 0/1/0", Count, Empty, DmMemWrite); end
      cyc;
      Reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc;
         n_cmp++; if (DmMemWrite !== 1'b0) begin n_fail++; $display("FAIL mid_nodrain%0d got %b want 0", i, DmMemWrite); end
      end
      n_cmp++; if (mem[40] !== 32'h0) begin n_fail++; $display("FAIL mid_mem got %h want 0", mem[40]); end
   endtask

   task automatic test_load_hit;
      cyc; drive(0, 1, 50, 32'h50);
      cyc; drive(1, 0, 50, 0);
`ifdef STORE_BUF_FWD_EN
      n_cmp++; if (Stall !== 1'b0 || ReadData !== 32'h50 || DmMemWrite !== 1'b0)
         begin n_fail++; $display("FAIL hit_fwd got st=%b rd=%h wr=%b want 0/50/0", Stall, ReadData, DmMemWrite); end
      cyc; drive(0, 0, 0, 0);
      cyc;
      n_cmp++; if (mem[50] !== 32'h50) begin n_fail++; $display("FAIL hit_mem got %h want 50", mem[50]); end
`else
      n_cmp++; if (Stall !== 1'b1 || DmMemWrite !== 1'b1 || DmMemRead !== 1'b0 || ReadData !== 32'h0)
         begin n_fail++; $display("FAIL hit_stall got st=%b wr=%b rd=%b d=%h want 1/1/0/0", Stall, DmMemWrite, DmMemRead, ReadData); end
      cyc;
      n_cmp++; if (Stall !== 1'b0 || ReadData !== 32'h50 || DmMemRead !== 1'b1)
         begin n_fail++; $display("FAIL hit_release got st=%b d=%h rd=%b want 0/50/1", Stall, ReadData, DmMemRead); end
      drive(0, 0, 0, 0);
`endif
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[7]  = 32'h55;
      mem[10] = 32'hAA;
      test_reset;
      test_basic_store;
      test_same_addr;
      test_load_miss;
      test_full_stall;
      test_simul;
      test_reset_mid;
      test_load_hit;
      cyc;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
